dmem_responder: RTL and testbench

Data-memory responder on the far side of the CPU's load/store interface. It accepts one request at a time from the Memory stage over a valid/ready handshake, waits a configurable number of cycles, then performs the word read or byte-enabled write. It returns a response over a second valid/ready handshake and stands in for a slow external data RAM, so the pipeline can be exercised against non-zero memory latency.

---
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time with fixed extra latency.
// Ports: clk/rst_n (sync, active-low), req_* handshake in, rsp_* handshake
// out. Build macro DMEM_ERR_CHECK_EN enables alignment/range error checks.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DAT_WIDTH-1:0]   req_wdata,
  input  logic [DAT_WIDTH/8-1:0] req_be,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DAT_WIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int BEW = DAT_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DAT_WIDTH-1:0]  r_wdata;
  logic [BEW-1:0]        r_be;
  logic [3:0]            r_cnt;
  logic [DAT_WIDTH-1:0]  r_rdata;
  logic                  r_err;

  logic [DAT_WIDTH-1:0]  r_mem [DEPTH_WORDS];

  logic                  w_do;
  logic                  w_sel_in;
  logic                  w_acc_wr;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [DAT_WIDTH-1:0]  w_acc_wdata;
  logic [BEW-1:0]        w_acc_be;
  logic [AW-1:0]         w_idx;
  logic                  w_bad;

  // With zero wait the access happens on the accept edge, straight
  // from the request inputs rather than the captured copy.
  assign w_sel_in    = (r_state == IDLE);
  assign w_acc_wr    = w_sel_in ? req_write : r_wr;
  assign w_acc_addr  = w_sel_in ? req_addr  : r_addr;
  assign w_acc_wdata = w_sel_in ? req_wdata : r_wdata;
  assign w_acc_be    = w_sel_in ? req_be    : r_be;
  assign w_idx       = w_acc_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
  logic w_oor;
  assign w_oor = ((w_acc_addr >> (AW + 2)) != '0);
  assign w_bad = (w_acc_addr[1:0] != 2'b00) | w_oor;
`else
  logic w_unused;
  assign w_unused = ^{w_acc_addr[1:0], w_acc_addr >> (AW + 2)};
  assign w_bad    = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_do   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_do   = 1'b1;
            w_next = RESP;
          end else begin
            w_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_do   = 1'b1;
          w_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_wr    <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= 4'(WAIT_CYCLES);
      end
      if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do) begin
        r_err <= w_bad;
        if (w_acc_wr || w_bad) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Array is not reset; rst_n only gates a pending commit.
  always_ff @(posedge clk) begin
    if (rst_n && w_do && w_acc_wr && !w_bad) begin
      for (int b = 0; b < BEW; b++) begin
        if (w_acc_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = rst_n & (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: scoreboard of expected responses
// against a byte-enable word model, latency and stall checks.
module tb_dmem_responder;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [1024];
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH (32),
    .DAT_WIDTH  (32),
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic xact(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  be,
    input  int          stall,
    output logic [31:0] got
  );
    logic [31:0] er;
    logic        ee;
    logic [32:0] e;
    int          n;
    ee = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    ee = (a[1:0] != 2'b00) || (a >= 32'h1000);
`endif
    er = '0;
    if (!ee) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        er = model[a[11:2]];
      end
    end
    sb.push_back({ee, er});
    got = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready got=%b want=1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    // junk on the request bus must not be taken while busy
    req_write = 1'b1;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'hF;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    total++;
    if (n >= 100) begin
      bad++;
      req_valid = 1'b0;
      $display("FAIL rsp_timeout a=%h", a);
      return;
    end
    if (n !== WAIT + 1) begin
      bad++;
      $display("FAIL latency a=%h got=%0d want=%0d", a, n, WAIT + 1);
    end
    got = rsp_rdata;
    total++;
    if (rsp_rdata !== e[31:0] || rsp_err !== e[32]) begin
      bad++;
      $display("FAIL rsp a=%h got=%h/%b want=%h/%b",
               a, rsp_rdata, rsp_err, e[31:0], e[32]);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e[31:0] ||
          rsp_err !== e[32] || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d v=%b d=%h e=%b rdy=%b want d=%h e=%b",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready,
                 e[31:0], e[32]);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_after v=%b rdy=%b want 0/1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset rdy=%b v=%b d=%h e=%b want 0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset rdy=%b want 1", req_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] g;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, g);
    total++;
    if (g !== 32'h0) begin
      bad++;
      $display("FAIL store_rdata got=%h want=0", g);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, g);
    total++;
    if (g !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_load got=%h want=deadbeef", g);
    end
  endtask

  task automatic test_partial_be;
    logic [31:0] g;
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, g);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, g);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, g);
    total++;
    if (g !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL partial_be got=%h want=11bb33dd", g);
    end
  endtask

  task automatic test_stall;
    logic [31:0] g;
    xact(1'b0, 32'h20, 32'h0, 4'h0, 5, g);
    total++;
    if (g !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL stall_load got=%h want=11bb33dd", g);
    end
  endtask

  task automatic test_reset_busy;
    logic [31:0] g;
    xact(1'b1, 32'h40, 32'h0, 4'hF, 0, g);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h55;
    req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy v=%b rdy=%b want 0/0",
               rsp_valid, req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    xact(1'b0, 32'h40, 32'h0, 4'h0, 0, g);
    total++;
    if (g !== 32'h0) begin
      bad++;
      $display("FAIL rst_busy_load got=%h want=0", g);
    end
  endtask

`ifdef DMEM_ERR_CHECK_EN
  task automatic test_err;
    logic [31:0] g;
    xact(1'b1, 32'h0, 32'h12345678, 4'hF, 0, g);
    xact(1'b0, 32'h2, 32'h0, 4'h0, 0, g);
    xact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, g);
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, g);
    total++;
    if (g !== 32'h12345678) begin
      bad++;
      $display("FAIL err_word0 got=%h want=12345678", g);
    end
  endtask
`else
  task automatic test_alias;
    logic [31:0] g;
    xact(1'b1, 32'h1004, 32'hCAFE0001, 4'hF, 0, g);
    xact(1'b0, 32'h0004, 32'h0, 4'h0, 0, g);
    total++;
    if (g !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL alias got=%h want=cafe0001", g);
    end
  endtask
`endif

  task automatic test_random;
    logic [31:0] g;
    logic [31:0] a;
    for (int i = 0; i < 8; i++)
      xact(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 0, g);
    for (int i = 0; i < 24; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      xact(1'($urandom), a, $urandom, 4'($urandom),
           $urandom_range(0, 2), g);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] g;
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, g);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, g);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, g);
    total++;
    if (g !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL b2b got=%h want=deadbeef", g);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_be();
    test_stall();
    test_reset_busy();
`ifdef DMEM_ERR_CHECK_EN
    test_err();
`else
    test_alias();
`endif
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
